// File: rtl/packet_tx.sv
// Source-side NoC packetizer: buffers payload words, holds one descriptor, emits header + payload flits in the TDM slot.
// Optional statistics counters (pkt_cnt, flit_cnt) are enabled by defining PACKET_TX_STATS_EN.
module packet_tx #(
   parameter int MAX_LEN    = 4,
   parameter int FIFO_DEPTH = 8,
   localparam int LW        = $clog2(MAX_LEN + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          desc_valid,
   output logic          desc_ready,
   input  logic [15:0]   desc_route,
   input  logic [15:0]   desc_addr,
   input  logic [LW-1:0] desc_len,
   output logic          desc_err,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [31:0]   wr_data,
   input  logic          slot_en,
   output logic          busy,
   output logic          outLine_req,
   output logic [34:0]   outLine_data
`ifdef PACKET_TX_STATS_EN
   ,
   output logic [15:0]   pkt_cnt,
   output logic [15:0]   flit_cnt
`endif
);

   // state | meaning
   // IDLE  | no descriptor held, desc_ready=1
   // WAIT  | descriptor held, waiting for slot and full payload
   // HDR   | header flit on the link, first payload word popped
   // PLD   | payload flit on the link, remaining words popped back-to-back
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HDR, S_PLD} state_t;

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [15:0]     r_route;
   logic [15:0]     r_addr;
   logic [LW-1:0]   r_len;
   logic [LW-1:0]   r_rem;
   logic [31:0]     r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;
   logic [34:0]     r_flit;
   logic            r_desc_err;

   logic            w_push;
   logic            w_pop;
   logic            w_desc_hs;
   logic            w_len_ok;
   logic            w_launch;
   logic [34:0]     w_flit_nxt;
   logic            w_err_nxt;

   assign desc_ready   = (r_state == S_IDLE);
   assign busy         = (r_state != S_IDLE);
   assign wr_ready     = (r_count < CW'(FIFO_DEPTH));
   assign outLine_data = r_flit;
   assign outLine_req  = r_flit[34];
   assign desc_err     = r_desc_err;

   assign w_push    = wr_valid & wr_ready;
   assign w_desc_hs = desc_valid & desc_ready;
   assign w_len_ok  = (desc_len != '0) && (desc_len <= LW'(MAX_LEN));
   assign w_launch  = slot_en && (r_count >= CW'(r_len));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_desc_hs && w_len_ok) w_state_nxt = S_WAIT;
         S_WAIT:  if (w_launch) w_state_nxt = S_HDR;
         S_HDR:   w_state_nxt = S_PLD;
         S_PLD:   if (r_rem == '0) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // The flit for the next cycle is formed here and registered below; pops run
   // while the header or a non-final payload flit is on the link.
   always_comb begin
      w_pop      = 1'b0;
      w_flit_nxt = '0;
      w_err_nxt  = 1'b0;
      case (r_state)
         S_IDLE: w_err_nxt = w_desc_hs && !w_len_ok;
         S_WAIT: if (w_launch) w_flit_nxt = {3'b110, r_addr, r_route};
         S_HDR:  w_pop = 1'b1;
         S_PLD:  w_pop = (r_rem != '0);
         default: ;
      endcase
      if (w_pop) w_flit_nxt = {1'b1, 1'b0, (r_rem == LW'(1)), r_mem[r_rptr]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_route    <= '0;
         r_addr     <= '0;
         r_len      <= '0;
         r_rem      <= '0;
         r_flit     <= '0;
         r_desc_err <= 1'b0;
      end else begin
         if (r_state == S_IDLE && w_desc_hs && w_len_ok) begin
            r_route <= desc_route;
            r_addr  <= desc_addr;
            r_len   <= desc_len;
         end
         if (r_state == S_WAIT && w_launch) r_rem <= r_len;
         else if (w_pop)                    r_rem <= r_rem - LW'(1);
         r_flit     <= w_flit_nxt;
         r_desc_err <= w_err_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef PACKET_TX_STATS_EN
   logic [15:0] r_pkt_cnt;
   logic [15:0] r_flit_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pkt_cnt  <= '0;
         r_flit_cnt <= '0;
      end else begin
         if (w_flit_nxt[34]) r_flit_cnt <= r_flit_cnt + 16'd1;
         if (w_flit_nxt[32]) r_pkt_cnt  <= r_pkt_cnt + 16'd1;
      end
   end

   assign pkt_cnt  = r_pkt_cnt;
   assign flit_cnt = r_flit_cnt;
`endif

endmodule

// File: tb/tb_packet_tx.sv
// Self-checking bench for packet_tx: a word queue models the FIFO, flits are derived from the descriptor and queued words.
module tb_packet_tx;
   localparam int MAX_LEN    = 4;
   localparam int FIFO_DEPTH = 8;
   localparam int LW         = $clog2(MAX_LEN + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          desc_valid = 1'b0;
   logic          desc_ready;
   logic [15:0]   desc_route = '0;
   logic [15:0]   desc_addr = '0;
   logic [LW-1:0] desc_len = '0;
   logic          desc_err;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [31:0]   wr_data = '0;
   logic          slot_en = 1'b0;
   logic          busy;
   logic          outLine_req;
   logic [34:0]   outLine_data;
`ifdef PACKET_TX_STATS_EN
   logic [15:0]   pkt_cnt;
   logic [15:0]   flit_cnt;
`endif

   packet_tx #(.MAX_LEN(MAX_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .reset(reset),
      .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_route(desc_route), .desc_addr(desc_addr), .desc_len(desc_len), .desc_err(desc_err),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .slot_en(slot_en), .busy(busy),
      .outLine_req(outLine_req), .outLine_data(outLine_data)
`ifdef PACKET_TX_STATS_EN
      , .pkt_cnt(pkt_cnt), .flit_cnt(flit_cnt)
`endif
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] mq[$];
   int          exp_pkts = 0;
   int          exp_flits = 0;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [31:0] w);
      logic exp_rdy;
      exp_rdy = (mq.size() < FIFO_DEPTH);
      n_vec++;
      if (wr_ready !== exp_rdy) begin
         n_err++;
         $display("FAIL wr_ready: got %b want %b (queued %0d)", wr_ready, exp_rdy, mq.size());
      end
      wr_valid = 1'b1;
      wr_data  = w;
      tick();
      wr_valid = 1'b0;
      if (exp_rdy) mq.push_back(w);
   endtask

   task automatic send_desc(input logic [15:0] route, input logic [15:0] addr, input logic [LW-1:0] len);
      logic exp_err;
      exp_err = (len == 0) || (int'(len) > MAX_LEN);
      n_vec++;
      if (desc_ready !== 1'b1) begin
         n_err++;
         $display("FAIL desc_ready_before: got %b want 1", desc_ready);
      end
      desc_valid = 1'b1;
      desc_route = route;
      desc_addr  = addr;
      desc_len   = len;
      tick();
      desc_valid = 1'b0;
      n_vec++;
      if (desc_err !== exp_err || outLine_data !== 35'h0) begin
         n_err++;
         $display("FAIL desc_err: got err=%b flit=%h want err=%b flit=0", desc_err, outLine_data, exp_err);
      end
   endtask

   task automatic wait_header(input logic [15:0] route, input logic [15:0] addr, input int budget, output int lat);
      logic [34:0] exp;
      exp = {3'b110, addr, route};
      lat = 0;
      while (outLine_data[34] !== 1'b1 && lat < budget) begin
         tick();
         lat++;
      end
      n_vec++;
      if (outLine_data !== exp || outLine_req !== 1'b1) begin
         n_err++;
         $display("FAIL header: got %h req=%b want %h req=1 (after %0d cycles)", outLine_data, outLine_req, exp, lat);
      end
      exp_flits++;
   endtask

   task automatic drain_payload(input int len, input bit rnd);
      logic [34:0] exp;
      logic [31:0] w;
      logic        do_push;
      for (int k = 0; k < len; k++) begin
         do_push = rnd && ($urandom_range(0, 2) == 0) && (mq.size() < FIFO_DEPTH);
         w = $urandom;
         if (do_push) begin
            n_vec++;
            if (wr_ready !== 1'b1) begin
               n_err++;
               $display("FAIL wr_ready_pld: got %b want 1", wr_ready);
            end
         end
         wr_valid = do_push;
         wr_data  = w;
         slot_en  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
         wr_valid = 1'b0;
         if (do_push) mq.push_back(w);
         if (mq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL model_underflow: got empty queue want %0d words", len - k);
            exp = '0;
         end else begin
            exp = {1'b1, 1'b0, (k == len - 1), mq.pop_front()};
         end
         n_vec++;
         if (outLine_data !== exp || outLine_req !== 1'b1) begin
            n_err++;
            $display("FAIL payload[%0d]: got %h req=%b want %h req=1", k, outLine_data, outLine_req, exp);
         end
         exp_flits++;
      end
      exp_pkts++;
      slot_en = 1'b0;
      tick();
      n_vec++;
      if (outLine_data !== 35'h0 || outLine_req !== 1'b0 || desc_ready !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL post_eop: got flit=%h req=%b rdy=%b busy=%b want 0/0/1/0",
                  outLine_data, outLine_req, desc_ready, busy);
      end
   endtask

   task automatic check_stats;
`ifdef PACKET_TX_STATS_EN
      n_vec++;
      if (pkt_cnt !== 16'(exp_pkts) || flit_cnt !== 16'(exp_flits)) begin
         n_err++;
         $display("FAIL stats: got pkt=%0d flit=%0d want pkt=%0d flit=%0d", pkt_cnt, flit_cnt, exp_pkts, exp_flits);
      end
`endif
   endtask

   task automatic test_reset;
      int lat;
      reset = 1'b1;
      tick();
      n_vec++;
      if (desc_ready !== 1'b1 || wr_ready !== 1'b1 || desc_err !== 1'b0 || busy !== 1'b0 ||
          outLine_req !== 1'b0 || outLine_data !== 35'h0) begin
         n_err++;
         $display("FAIL reset_values: got rdy=%b wrdy=%b err=%b busy=%b req=%b flit=%h want 1/1/0/0/0/0",
                  desc_ready, wr_ready, desc_err, busy, outLine_req, outLine_data);
      end
      reset = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) push_word($urandom);
      send_desc(16'h1234, 16'h5678, 3'd3);
      slot_en = 1'b1;
      wait_header(16'h1234, 16'h5678, 4, lat);
      slot_en = 1'b0;
      tick();
      n_vec++;
      if (busy !== 1'b1 || outLine_data[34] !== 1'b1) begin
         n_err++;
         $display("FAIL mid_pld: got busy=%b vld=%b want 1/1", busy, outLine_data[34]);
      end
      reset = 1'b1;
      #1;
      n_vec++;
      if (outLine_data !== 35'h0 || busy !== 1'b0 || outLine_req !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: got flit=%h busy=%b req=%b want 0/0/0", outLine_data, busy, outLine_req);
      end
      tick();
      reset = 1'b0;
      mq.delete();
      exp_pkts  = 0;
      exp_flits = 0;
      tick();
      n_vec++;
      if (wr_ready !== 1'b1 || desc_ready !== 1'b1) begin
         n_err++;
         $display("FAIL after_reset: got wrdy=%b rdy=%b want 1/1", wr_ready, desc_ready);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_vec++;
         if (outLine_data !== 35'h0) begin
            n_err++;
            $display("FAIL no_resume: got %h want 0", outLine_data);
         end
      end
      check_stats();
   endtask

   task automatic test_basic;
      int lat;
      push_word(32'hA5A5_0001);
      push_word(32'hA5A5_0002);
      send_desc(16'h00E4, 16'h0100, 3'd2);
      slot_en = 1'b1;
      wait_header(16'h00E4, 16'h0100, 4, lat);
      n_vec++;
      if (outLine_data !== 35'h6_0100_00E4 || lat !== 1) begin
         n_err++;
         $display("FAIL basic_header: got %h lat=%0d want 6010000e4 lat=1", outLine_data, lat);
      end
      drain_payload(2, 1'b0);
   endtask

   task automatic test_insufficient;
      int lat;
      push_word($urandom);
      push_word($urandom);
      send_desc(16'hBEEF, 16'h0042, 3'd3);
      slot_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_vec++;
         if (outLine_data !== 35'h0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL short_wait: got flit=%h busy=%b want 0/1", outLine_data, busy);
         end
      end
      push_word($urandom);
      n_vec++;
      if (outLine_data !== 35'h0) begin
         n_err++;
         $display("FAIL push_edge: got %h want 0", outLine_data);
      end
      wait_header(16'hBEEF, 16'h0042, 4, lat);
      n_vec++;
      if (lat !== 1) begin
         n_err++;
         $display("FAIL header_latency: got %0d want 1", lat);
      end
      drain_payload(3, 1'b0);
   endtask

   task automatic test_slot_gate;
      int lat;
      slot_en = 1'b0;
      for (int i = 0; i < 4; i++) push_word($urandom);
      send_desc(16'h0003, 16'hCAFE, 3'd4);
      for (int i = 0; i < 6; i++) begin
         tick();
         n_vec++;
         if (outLine_data !== 35'h0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL slot_closed: got flit=%h busy=%b want 0/1", outLine_data, busy);
         end
      end
      slot_en = 1'b1;
      tick();
      slot_en = 1'b0;
      wait_header(16'h0003, 16'hCAFE, 0, lat);
      drain_payload(4, 1'b0);
   endtask

   task automatic test_desc_err;
      logic [LW-1:0] bad [2];
      bad[0] = '0;
      bad[1] = LW'(MAX_LEN + 1);
      for (int i = 0; i < 2; i++) begin
         send_desc($urandom, $urandom, bad[i]);
         tick();
         n_vec++;
         if (desc_err !== 1'b0 || desc_ready !== 1'b1 || busy !== 1'b0 || outLine_data !== 35'h0) begin
            n_err++;
            $display("FAIL err_pulse[%0d]: got err=%b rdy=%b busy=%b flit=%h want 0/1/0/0",
                     i, desc_err, desc_ready, busy, outLine_data);
         end
      end
   endtask

   task automatic test_fifo_full;
      int lat;
      slot_en = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) push_word($urandom);
      n_vec++;
      if (wr_ready !== 1'b0) begin
         n_err++;
         $display("FAIL full: got wr_ready=%b want 0", wr_ready);
      end
      push_word($urandom);
      push_word($urandom);
      for (int p = 0; p < 2; p++) begin
         send_desc(16'h00A0 + 16'(p), 16'h2000 + 16'(p), 3'd4);
         slot_en = 1'b1;
         wait_header(16'h00A0 + 16'(p), 16'h2000 + 16'(p), 4, lat);
         drain_payload(4, 1'b0);
      end
      check_stats();
   endtask

   task automatic test_random;
      int          lat;
      int          len;
      logic [15:0] route;
      logic [15:0] addr;
      logic        s;
      for (int p = 0; p < 25; p++) begin
         len   = $urandom_range(1, MAX_LEN);
         route = $urandom;
         addr  = $urandom;
         slot_en = 1'b0;
         while (mq.size() < len) begin
            if ($urandom_range(0, 1) == 1) push_word($urandom);
            else tick();
         end
         send_desc(route, addr, LW'(len));
         for (int c = 0; c < 40; c++) begin
            s = (c >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
            slot_en = s;
            tick();
            if (s) break;
            n_vec++;
            if (outLine_data !== 35'h0) begin
               n_err++;
               $display("FAIL rnd_gate: got %h want 0", outLine_data);
            end
         end
         wait_header(route, addr, 0, lat);
         drain_payload(len, 1'b1);
      end
      check_stats();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_insufficient();
      test_slot_gate();
      test_desc_err();
      test_fifo_full();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
